// File: rtl/deserializer.sv
// Rebuilds an OUTPUT_SIZE-bit frame from CHUNK_SIZE-bit serial chunks (word 0 in LSBs, first chunk of a word in its MS half).
// Optional idle-gap timeout with frame_error pulse when DESER_TIMEOUT_EN is defined.
module deserializer #(
    parameter int unsigned OUTPUT_SIZE    = 256,
    parameter int unsigned CHUNK_SIZE     = 16,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   input_valid,
    input  logic [CHUNK_SIZE-1:0]  input_data,
    output logic                   output_valid,
    output logic [OUTPUT_SIZE-1:0] output_data,
    output logic                   busy,
    output logic                   frame_error
);

    localparam int unsigned N  = OUTPUT_SIZE / CHUNK_SIZE;
    localparam int unsigned C  = WORD_SIZE / CHUNK_SIZE;
    localparam int unsigned CW = $clog2(N) + 1;

    if ((WORD_SIZE % CHUNK_SIZE) != 0 || (OUTPUT_SIZE % WORD_SIZE) != 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_err
        $error("deserializer: illegal size/timeout parameter combination");
    end

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_eff;
    logic [OUTPUT_SIZE-1:0] buf_q, buf_d, placed;
    logic [OUTPUT_SIZE-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   timeout_fire;

`ifdef DESER_TIMEOUT_EN
    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;

    assign timeout_fire = (state_q == COLLECT) && (gap_q == GW'(TIMEOUT_CYCLES));
    assign frame_error  = err_q;
`else
    assign timeout_fire = 1'b0;
    assign frame_error  = 1'b0;
`endif

    // A chunk in the cycle the timeout fires starts a fresh frame.
    assign cnt_eff = timeout_fire ? '0 : cnt_q;

    always_comb begin
        placed = buf_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_eff == CW'(k)) begin
                placed[(k / C) * WORD_SIZE + WORD_SIZE - ((k % C) + 1) * CHUNK_SIZE +: CHUNK_SIZE] = input_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef DESER_TIMEOUT_EN
        gap_d   = gap_q;
        err_d   = 1'b0;
`endif
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef DESER_TIMEOUT_EN
            gap_d   = '0;
`endif
        end else begin
            if (timeout_fire) begin
                state_d = IDLE;
                cnt_d   = '0;
`ifdef DESER_TIMEOUT_EN
                gap_d   = '0;
                err_d   = 1'b1;
`endif
            end
            if (input_valid) begin
                buf_d = placed;
`ifdef DESER_TIMEOUT_EN
                gap_d = '0;
`endif
                if (cnt_eff == CW'(N - 1)) begin
                    data_d  = placed;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_eff + 1'b1;
                    state_d = COLLECT;
                end
            end else if (state_q == COLLECT && !timeout_fire) begin
`ifdef DESER_TIMEOUT_EN
                gap_d = gap_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef DESER_TIMEOUT_EN
            gap_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef DESER_TIMEOUT_EN
            gap_q   <= gap_d;
            err_q   <= err_d;
`endif
        end
    end

    assign output_valid = valid_q;
    assign output_data  = data_q;
    assign busy         = (state_q == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: chunk-list reference model checked every cycle, plus literal frame checks.
module tb_deserializer;

    localparam int OS = 256;
    localparam int CS = 16;
    localparam int WS = 32;
    localparam int TO = 4;
    localparam int N  = OS / CS;
`ifdef DESER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          input_valid = 1'b0;
    logic [CS-1:0] input_data = '0;
    logic          output_valid;
    logic [OS-1:0] output_data;
    logic          busy;
    logic          frame_error;

    always #5 clk = ~clk;

    deserializer #(
        .OUTPUT_SIZE   (OS),
        .CHUNK_SIZE    (CS),
        .WORD_SIZE     (WS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .input_valid (input_valid),
        .input_data  (input_data),
        .output_valid(output_valid),
        .output_data (output_data),
        .busy        (busy),
        .frame_error (frame_error)
    );

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int ecnt = 0;

    task automatic check(input string name, input logic [OS-1:0] act, input logic [OS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: list of chunks received so far in the current frame.
    int            m_count = 0;
    int            m_gap = 0;
    logic [CS-1:0] m_chunks[N];
    logic [OS-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_err = 1'b0;

    function automatic logic [OS-1:0] assemble();
        logic [OS-1:0] f;
        f = '0;
        for (int w = 0; w < N / 2; w++) f[w*WS +: WS] = {m_chunks[2*w], m_chunks[2*w+1]};
        return f;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_count = 0; m_gap = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (clear) begin
                m_count = 0; m_gap = 0;
            end else begin
                if (TO_EN && m_count > 0 && m_gap == TO) begin
                    m_err = 1'b1; m_count = 0; m_gap = 0;
                end
                if (input_valid) begin
                    m_chunks[m_count] = input_data;
                    m_count++;
                    m_gap = 0;
                    if (m_count == N) begin
                        m_data  = assemble();
                        m_valid = 1'b1;
                        m_count = 0;
                    end
                end else if (m_count > 0) begin
                    m_gap++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("output_valid", {255'b0, output_valid}, {255'b0, m_valid});
        check("output_data", output_data, m_data);
        check("busy", {255'b0, busy}, {255'b0, (m_count > 0)});
        check("frame_error", {255'b0, frame_error}, {255'b0, m_err});
        if (output_valid === 1'b1) vcnt++;
        if (frame_error === 1'b1) ecnt++;
    end

    task automatic send(input logic [CS-1:0] d);
        input_valid = 1'b1;
        input_data  = d;
        @(posedge clk); #1;
        input_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [OS-1:0] frame1, hold;
    int v0, e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {255'b0, output_valid}, '0);
        check("reset_data", output_data, '0);
        check("reset_busy", {255'b0, busy}, '0);
        check("reset_err", {255'b0, frame_error}, '0);
        reset = 1'b0;
        idle(2);

        // Contiguous frame 0x0001..0x0010
        for (int k = 1; k <= N; k++) begin
            send(CS'(k));
            if (k == 1) check("busy_after_first", {255'b0, busy}, 256'd1);
        end
        check("t1_valid", {255'b0, output_valid}, 256'd1);
        check("t1_w0", {224'b0, output_data[31:0]}, 256'h0001_0002);
        check("t1_w1", {224'b0, output_data[63:32]}, 256'h0003_0004);
        check("t1_w7", {224'b0, output_data[255:224]}, 256'h000F_0010);
        frame1 = output_data;
        idle(1);
        check("t1_pulse_end", {255'b0, output_valid}, '0);
        check("t1_busy_end", {255'b0, busy}, '0);

        // Same chunks with 3 idle cycles after each
        v0 = vcnt; e0 = ecnt;
        for (int k = 1; k <= N; k++) begin
            send(CS'(k));
            idle(3);
        end
        check("t2_pulses", 256'(vcnt - v0), 256'd1);
        check("t2_errors", 256'(ecnt - e0), 256'd0);
        check("t2_data", output_data, frame1);

        // Back-to-back frames A and B
        v0 = vcnt;
        for (int k = 0; k < N; k++) send(16'hA000 + CS'(k));
        check("t3_a_valid", {255'b0, output_valid}, 256'd1);
        check("t3_a_w0", {224'b0, output_data[31:0]}, 256'hA000_A001);
        for (int k = 0; k < N; k++) send(16'hB000 + CS'(k));
        check("t3_b_valid", {255'b0, output_valid}, 256'd1);
        check("t3_b_w0", {224'b0, output_data[31:0]}, 256'hB000_B001);
        idle(1);
        check("t3_pulses", 256'(vcnt - v0), 256'd2);

        // Clear with a 6th chunk, then a frame of 0x1111
        for (int k = 0; k < 5; k++) send(16'h5000 + CS'(k));
        hold = output_data;
        v0 = vcnt;
        clear = 1'b1;
        send(16'h5005);
        clear = 1'b0;
        check("t4_busy_after_clear", {255'b0, busy}, '0);
        check("t4_valid_after_clear", {255'b0, output_valid}, '0);
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) check("t4_held", output_data, hold);
            send(16'h1111);
        end
        idle(1);
        check("t4_pulses", 256'(vcnt - v0), 256'd1);
        check("t4_data", output_data, {16{16'h1111}});

        // Asynchronous reset mid-frame
        for (int k = 0; k < 8; k++) send(16'h3000 + CS'(k));
        #1 reset = 1'b1;
        #1;
        check("t5_rst_valid", {255'b0, output_valid}, '0);
        check("t5_rst_data", output_data, '0);
        check("t5_rst_busy", {255'b0, busy}, '0);
        check("t5_rst_err", {255'b0, frame_error}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < N; k++) send(16'h2000 + CS'(k));
        check("t5_valid", {255'b0, output_valid}, 256'd1);
        check("t5_w0", {224'b0, output_data[31:0]}, 256'h2000_2001);
        check("t5_w7", {224'b0, output_data[255:224]}, 256'h200E_200F);
        idle(2);

`ifdef DESER_TIMEOUT_EN
        e0 = ecnt;
        hold = output_data;
        for (int k = 0; k < 3; k++) send(16'h7000 + CS'(k));
        idle(6);
        check("t6_err_pulses", 256'(ecnt - e0), 256'd1);
        check("t6_busy", {255'b0, busy}, '0);
        check("t6_data_held", output_data, hold);
        for (int k = 0; k < N; k++) send(16'h8000 + CS'(k));
        check("t6_valid", {255'b0, output_valid}, 256'd1);
        check("t6_w0", {224'b0, output_data[31:0]}, 256'h8000_8001);
        idle(2);
`else
        check("no_timeout_errors", 256'(ecnt), 256'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
